integration_sw_poller: RTL and testbench

- Avalon-MM master that periodically reads the 16-bit switch PIO data register (address 0) and debounces the samples.
- Sends each debounced change to the S4PU core as an event on a valid/ready handshake.
- Sits between the switch PIO slave and the core, so the core never polls the PIO directly.
- Owns the read sequencing and the poll-rate schedule for the PIO.

---
 rtl/integration_sw_pkg.sv | 21 ++
 rtl/integration_sw_debounce.sv | 52 +++++
 rtl/integration_sw_poller.sv | 156 +++++++++++++++
 tb/tb_integration_sw_poller.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/integration_sw_pkg.sv
// Shared types and constants for the switch poller.
package integration_sw_pkg;

  // Read sequencing states of the poller.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    EVAL = 2'd3
  } poll_state_e;

  // The switch PIO exposes its data register at word address 0.
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  // Default build: 1 ms poll at 50 MHz, four agreeing samples, one-cycle PIO.
  localparam int DEF_POLL_DIV       = 50000;
  localparam int DEF_STABLE_SAMPLES = 4;
  localparam int DEF_READ_LATENCY   = 1;
  localparam int DEF_DATA_W         = 16;

endpackage

// File: rtl/integration_sw_debounce.sv
// Debouncer: tracks a candidate value and how many consecutive samples agreed
// with it. Commit is combinational in the sample cycle so the caller can
// register the new value and its event together.
module integration_sw_debounce
  import integration_sw_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int DATA_W         = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] committed,
  output logic              commit,
  output logic [DATA_W-1:0] commit_value
);

  localparam int              CNT_W   = $clog2(STABLE_SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_SAMPLES);

  logic [DATA_W-1:0] r_cand;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_cand_next;
  logic [CNT_W-1:0]  w_cnt_next;

  // Next candidate/count: a repeat extends the run (saturating), anything else restarts it.
  always_comb begin
    w_cand_next = sample;
    w_cnt_next  = CNT_W'(1);
    if (sample == r_cand) begin
      w_cand_next = r_cand;
      w_cnt_next  = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_W'(1);
    end
  end

  // A run long enough that differs from the committed value is a new state.
  assign commit       = sample_valid && (w_cnt_next == CNT_MAX) && (w_cand_next != committed);
  assign commit_value = w_cand_next;

  // Candidate and run length only move when a fresh sample arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand <= '0;
      r_cnt  <= '0;
    end else if (sample_valid) begin
      r_cand <= w_cand_next;
      r_cnt  <= w_cnt_next;
    end
  end

endmodule

// File: rtl/integration_sw_poller.sv
// Avalon-MM master that polls the switch PIO, debounces the samples and
// reports every committed change to the core over a valid/ready event port.
module integration_sw_poller
  import integration_sw_pkg::*;
#(
  parameter int POLL_DIV       = DEF_POLL_DIV,
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int READ_LATENCY   = DEF_READ_LATENCY,
  parameter int DATA_W         = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [1:0]        m_address,
  output logic              m_read,
  input  logic              m_waitrequest,
  input  logic [31:0]       m_readdata,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [DATA_W-1:0] ev_data,
  output logic [DATA_W-1:0] ev_changed,
  output logic              ev_overflow,
  output logic [DATA_W-1:0] sw_state
);

  localparam int PC_W  = $clog2(POLL_DIV);
  localparam int LAT_W = $clog2(READ_LATENCY + 1);

  poll_state_e       r_state;
  logic [PC_W-1:0]   r_poll_cnt;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [DATA_W-1:0] r_sample;
  logic              r_read;
  logic              r_ev_valid;
  logic [DATA_W-1:0] r_ev_data;
  logic [DATA_W-1:0] r_ev_changed;
  logic              r_ev_overflow;
  logic [DATA_W-1:0] r_sw_state;

  logic              w_wrap;
  logic              w_accept;
  logic              w_commit;
  logic [DATA_W-1:0] w_commit_value;
  logic [DATA_W-1:0] w_diff;
  logic              w_unused_rdata;

  assign w_wrap         = (r_poll_cnt == PC_W'(POLL_DIV - 1));
  assign w_accept       = r_ev_valid && ev_ready;
  assign w_diff         = w_commit_value ^ r_sw_state;
  // Upper PIO bits carry nothing for this block.
  assign w_unused_rdata = ^m_readdata;

  // Free-running poll schedule; parked at zero only while idle and disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_poll_cnt <= '0;
    end else if (r_state == IDLE && !enable) begin
      r_poll_cnt <= '0;
    end else if (w_wrap) begin
      r_poll_cnt <= '0;
    end else begin
      r_poll_cnt <= r_poll_cnt + PC_W'(1);
    end
  end

  // Read sequencer: launch on wrap, hold through stalls, capture after the fixed latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_read    <= 1'b0;
      r_lat_cnt <= '0;
      r_sample  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_wrap && enable) begin
            r_state <= REQ;
            r_read  <= 1'b1;
          end
        end
        REQ: begin
          if (!m_waitrequest) begin
            r_state   <= WAIT;
            r_read    <= 1'b0;
            r_lat_cnt <= '0;
          end
        end
        WAIT: begin
          if (r_lat_cnt == LAT_W'(READ_LATENCY - 1)) begin
            r_sample <= m_readdata[DATA_W-1:0];
            r_state  <= EVAL;
          end else begin
            r_lat_cnt <= r_lat_cnt + LAT_W'(1);
          end
        end
        EVAL: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_read  <= 1'b0;
        end
      endcase
    end
  end

  integration_sw_debounce #(
    .STABLE_SAMPLES (STABLE_SAMPLES),
    .DATA_W         (DATA_W)
  ) u_debounce (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (r_state == EVAL),
    .sample       (r_sample),
    .committed    (r_sw_state),
    .commit       (w_commit),
    .commit_value (w_commit_value)
  );

  // Committed state and event register; an unconsumed event absorbs newer commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_state    <= '0;
      r_ev_valid    <= 1'b0;
      r_ev_data     <= '0;
      r_ev_changed  <= '0;
      r_ev_overflow <= 1'b0;
    end else if (w_commit) begin
      r_sw_state <= w_commit_value;
      r_ev_data  <= w_commit_value;
      r_ev_valid <= 1'b1;
      if (!r_ev_valid || ev_ready) begin
        r_ev_changed <= w_diff;
        if (r_ev_valid) begin
          r_ev_overflow <= 1'b0;
        end
      end else begin
        r_ev_changed  <= r_ev_changed | w_diff;
        r_ev_overflow <= 1'b1;
      end
    end else if (w_accept) begin
      r_ev_valid    <= 1'b0;
      r_ev_changed  <= '0;
      r_ev_overflow <= 1'b0;
    end
  end

  assign m_address   = PIO_DATA_ADDR;
  assign m_read      = r_read;
  assign ev_valid    = r_ev_valid;
  assign ev_data     = r_ev_data;
  assign ev_changed  = r_ev_changed;
  assign ev_overflow = r_ev_overflow;
  assign sw_state    = r_sw_state;

endmodule

// File: tb/tb_integration_sw_poller.sv
// Bench for the switch poller: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a transaction-level model.
module tb_integration_sw_poller;

  localparam int DIV = 4;
  localparam int STB = 3;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        m_waitrequest = 1'b0;
  logic        ev_ready = 1'b0;
  logic [15:0] in_port = 16'h0000;
  logic [15:0] upper = 16'h0000;
  logic [31:0] m_readdata;
  logic [1:0]  m_address;
  logic        m_read;
  logic        ev_valid;
  logic [15:0] ev_data;
  logic [15:0] ev_changed;
  logic        ev_overflow;
  logic [15:0] sw_state;

  assign m_readdata = {upper, in_port};

  always #5 clk = ~clk;

  integration_sw_poller #(
    .POLL_DIV       (DIV),
    .STABLE_SAMPLES (STB),
    .READ_LATENCY   (LAT),
    .DATA_W         (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .m_address     (m_address),
    .m_read        (m_read),
    .m_waitrequest (m_waitrequest),
    .m_readdata    (m_readdata),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_data       (ev_data),
    .ev_changed    (ev_changed),
    .ev_overflow   (ev_overflow),
    .sw_state      (sw_state)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model (updated on every rising edge) ----------------
  int          cyc = 0;
  bit          mr_req = 1'b0;     // a read request is being presented
  bit          mr_pend = 1'b0;    // an accepted read has not been evaluated yet
  int          mr_cap = 0;        // edge at which read data is captured
  int          mr_apply = 0;      // edge at which the sample is debounced
  int          mcnt = 0;
  logic [15:0] msample = '0;
  logic [15:0] hist[$];
  logic [15:0] msw = '0;
  logic [15:0] mdata = '0;
  logic [15:0] mchg = '0;
  bit          mvalid = 1'b0;
  bit          movf = 1'b0;
  int          n_applied = 0;

  always @(posedge clk) begin : model
    bit          idle;
    bit          commit;
    bit          same;
    logic [15:0] cand;
    cyc++;
    if (reset) begin
      mr_req = 0; mr_pend = 0; mcnt = 0; msample = '0;
      hist.delete();
      msw = '0; mdata = '0; mchg = '0; mvalid = 0; movf = 0;
    end else begin
      idle   = !mr_req && !mr_pend;
      commit = 0;
      cand   = '0;
      if (mr_pend && cyc == mr_apply) begin
        hist.push_back(msample);
        if (hist.size() > STB) void'(hist.pop_front());
        n_applied++;
        same = (hist.size() == STB);
        foreach (hist[k]) if (hist[k] != hist[0]) same = 0;
        if (same && hist[0] != msw) begin
          commit = 1;
          cand   = hist[0];
        end
        mr_pend = 0;
      end
      if (mr_pend && cyc == mr_cap) msample = m_readdata[15:0];
      if (commit) begin
        if (!mvalid || ev_ready) begin
          mchg = cand ^ msw;
          if (mvalid) movf = 0;
        end else begin
          mchg = mchg | (cand ^ msw);
          movf = 1;
        end
        mdata = cand; mvalid = 1; msw = cand;
      end else if (mvalid && ev_ready) begin
        mvalid = 0; mchg = '0; movf = 0;
      end
      if (mr_req && !m_waitrequest) begin
        mr_req   = 0;
        mr_pend  = 1;
        mr_cap   = cyc + LAT;
        mr_apply = cyc + LAT + 1;
      end else if (idle && mcnt == DIV - 1 && enable) begin
        mr_req = 1;
      end
      mcnt = (idle && !enable) ? 0 : (mcnt + 1) % DIV;
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_read", m_read, mr_req);
      chk("m_address", m_address, 2'd0);
      chk("ev_valid", ev_valid, mvalid);
      chk("ev_data", ev_data, mdata);
      chk("ev_changed", ev_changed, mchg);
      chk("ev_overflow", ev_overflow, movf);
      chk("sw_state", sw_state, msw);
    end
  end

  // DUT read-launch monitor for poll spacing checks.
  int rise_last = 0;
  int rise_prev = 0;
  bit mread_d = 1'b0;
  always @(negedge clk) begin
    if (m_read && !mread_d) begin
      rise_prev = rise_last;
      rise_last = cyc;
    end
    mread_d = m_read;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_samples(input int n);
    int target;
    int budget;
    target = n_applied + n;
    budget = 200;
    while (n_applied < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("sample_wait", (n_applied >= target), 1);
  endtask

  task automatic feed(input logic [15:0] v);
    in_port = v;
    wait_samples(1);
  endtask

  task automatic wait_mread(input logic lvl);
    int budget;
    budget = 60;
    while (m_read !== lvl && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("m_read_wait", m_read, lvl);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    int n0;
    int waited;
    logic [15:0] vals[6];
    vals[0] = 16'h0000; vals[1] = 16'h0001; vals[2] = 16'h0003;
    vals[3] = 16'h00A5; vals[4] = 16'hFFFF; vals[5] = 16'h8421;

    // Reset state.
    upper   = 16'hDEAD;
    in_port = 16'h00A5;
    step(2);
    chk("rst_m_read", m_read, 0);
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_ev_data", ev_data, 0);
    chk("rst_ev_changed", ev_changed, 0);
    chk("rst_ev_overflow", ev_overflow, 0);
    chk("rst_sw_state", sw_state, 0);
    cmp_on = 1'b1;
    reset  = 1'b0;
    enable = 1'b1;

    // Steady input commits on the third sample.
    wait_samples(2);
    chk("a5_early_valid", ev_valid, 0);
    wait_samples(1);
    chk("a5_valid", ev_valid, 1);
    chk("a5_data", ev_data, 16'h00A5);
    chk("a5_changed", ev_changed, 16'h00A5);
    chk("a5_sw_state", sw_state, 16'h00A5);
    chk("a5_poll_spacing", rise_last - rise_prev, DIV);

    // Bounce from zero: only the fifth sample commits.
    in_port = 16'h0001;
    do_reset();
    feed(16'h0001); chk("bounce1_valid", ev_valid, 0);
    feed(16'h0000); chk("bounce2_valid", ev_valid, 0);
    feed(16'h0001); chk("bounce3_valid", ev_valid, 0);
    feed(16'h0001); chk("bounce4_valid", ev_valid, 0);
    feed(16'h0001);
    chk("bounce5_valid", ev_valid, 1);
    chk("bounce5_changed", ev_changed, 16'h0001);
    chk("bounce5_sw", sw_state, 16'h0001);

    // Two commits without acceptance merge into one overflowed event.
    in_port  = 16'h0003;
    ev_ready = 1'b0;
    do_reset();
    repeat (3) feed(16'h0003);
    chk("ovf_first_changed", ev_changed, 16'h0003);
    repeat (3) feed(16'h0002);
    chk("ovf_valid", ev_valid, 1);
    chk("ovf_data", ev_data, 16'h0002);
    chk("ovf_changed", ev_changed, 16'h0003);
    chk("ovf_flag", ev_overflow, 1);
    ev_ready = 1'b1;
    step(1);
    ev_ready = 1'b0;
    chk("ovf_acc_valid", ev_valid, 0);
    chk("ovf_acc_flag", ev_overflow, 0);
    chk("ovf_acc_changed", ev_changed, 0);

    // Stall the request for five edges.
    wait_mread(1'b0);
    wait_mread(1'b1);
    m_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_m_read", m_read, 1);
      step(1);
    end
    m_waitrequest = 1'b0;
    chk("stall_accept_m_read", m_read, 1);
    step(1);
    chk("stall_after_m_read", m_read, 0);
    wait_mread(1'b1);
    step(1);
    chk("stall_realign", rise_last - rise_prev, 3 * DIV);

    // Drop enable in the acceptance cycle.
    wait_mread(1'b0);
    wait_mread(1'b1);
    n0 = n_applied;
    enable = 1'b0;
    step(4);
    chk("dis_read_done", n_applied - n0, 1);
    for (int i = 0; i < 20; i++) begin
      chk("dis_no_read", m_read, 0);
      step(1);
    end
    enable = 1'b1;
    waited = 0;
    while (m_read !== 1'b1 && waited < 40) begin
      step(1);
      waited++;
    end
    chk("reenable_delay", waited, DIV);

    // Reset while the read is in flight; the late data must be ignored.
    wait_mread(1'b0);
    wait_mread(1'b1);
    step(1);
    reset = 1'b1;
    step(1);
    chk("midrst_m_read", m_read, 0);
    chk("midrst_sw", sw_state, 0);
    chk("midrst_valid", ev_valid, 0);
    reset   = 1'b0;
    in_port = 16'hFFFF;
    step(1);
    in_port = 16'h0000;
    chk("midrst_late_sw", sw_state, 0);
    step(12);
    chk("midrst_hold_sw", sw_state, 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      upper = 16'($urandom);
      if ($urandom_range(0, 11) == 0) in_port = vals[$urandom_range(0, 5)];
      ev_ready      = ($urandom_range(0, 2) == 0);
      m_waitrequest = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      reset = ($urandom_range(0, 599) == 0);
      step(1);
    end
    reset = 1'b0;
    m_waitrequest = 1'b0;
    step(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
